// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the data-memory arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   byte_mask_t : 3-bit load/store width code, same encoding as the datapath
//   PORT_CORE / PORT_EXT : requester ids used for grant_id
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef logic [2:0] byte_mask_t;

  localparam byte_mask_t MASK_B  = 3'b000;
  localparam byte_mask_t MASK_H  = 3'b001;
  localparam byte_mask_t MASK_W  = 3'b010;
  localparam byte_mask_t MASK_BU = 3'b100;
  localparam byte_mask_t MASK_HU = 3'b101;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_EXT  = 1'b1;

endpackage : rv32i_pkg

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way grant pick.
//   valid0_i, valid1_i : request valids of port 0 / port 1
//   prefer_i           : port that wins when both are valid
//   gnt_any_o          : at least one request is valid
//   gnt_id_o           : winning port id (meaningful when gnt_any_o)
module dmem_arb_pick
  import rv32i_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic prefer_i,
  output logic gnt_any_o,
  output logic gnt_id_o
);

  // Contention resolves to prefer_i; otherwise the lone requester wins.
  always_comb begin
    gnt_any_o = valid0_i | valid1_i;
    gnt_id_o  = PORT_CORE;
    if (valid0_i && valid1_i) begin
      gnt_id_o = prefer_i;
    end else if (valid1_i) begin
      gnt_id_o = PORT_EXT;
    end
  end

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-cycle data memory.
// Port 0 is the core load/store port, port 1 the external loader/debug port.
// One transaction at a time: accept (IDLE) -> memory access (ACCESS) ->
// one-cycle response (RESP) -> IDLE.
//   clk, rst                    : clock, asynchronous active-high reset
//   pN_valid/pN_ready           : request handshake (ready combinational in IDLE)
//   pN_addr/wen/wdata/mask      : request fields, sampled on acceptance
//   pN_resp_valid/pN_rdata      : response strobe and held read data
//   mem_addr/wen/wdata/mask     : memory drive, non-zero only in ACCESS
//   mem_rdata                   : combinational memory read data
//   busy, grant_id              : transaction in flight / its owner
// Build option: DMEM_ARBITER_ROUND_ROBIN_EN selects round-robin contention
// resolution; when undefined port 0 always wins contention.
module dmem_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_wen,
  input  logic [DATA_W-1:0] p0_wdata,
  input  byte_mask_t        p0_mask,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_wen,
  input  logic [DATA_W-1:0] p1_wdata,
  input  byte_mask_t        p1_mask,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output byte_mask_t        mem_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("dmem_arbiter: DATA_W must be 32");
  end

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  byte_mask_t        mask_q, mask_d;
  logic              grant_q, grant_d;
  logic              resp0_q, resp1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              ready0_c, ready1_c;
  logic              prefer;
  logic              gnt_any, gnt_id;
  logic              in_access;

  // Contention preference: rotating pointer or fixed port 0.
`ifdef DMEM_ARBITER_ROUND_ROBIN_EN
  logic prefer_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_q <= PORT_CORE;
    end else if (ready0_c || ready1_c) begin
      prefer_q <= ~gnt_id;
    end
  end

  assign prefer = prefer_q;
`else
  assign prefer = PORT_CORE;
`endif

  dmem_arb_pick u_pick (
    .valid0_i  (p0_valid),
    .valid1_i  (p1_valid),
    .prefer_i  (prefer),
    .gnt_any_o (gnt_any),
    .gnt_id_o  (gnt_id)
  );

  // FSM state and latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= MASK_B;
      grant_q <= PORT_CORE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
    end
  end

  // Next state, acceptance and field capture.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    grant_d  = grant_q;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst so no ready leaks out while reset is held.
        if (gnt_any && !rst) begin
          grant_d = gnt_id;
          state_d = ST_ACCESS;
          if (gnt_id == PORT_EXT) begin
            ready1_c = 1'b1;
            addr_d   = p1_addr;
            wen_d    = p1_wen;
            wdata_d  = p1_wdata;
            mask_d   = p1_mask;
          end else begin
            ready0_c = 1'b1;
            addr_d   = p0_addr;
            wen_d    = p0_wen;
            wdata_d  = p0_wdata;
            mask_d   = p0_mask;
          end
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Response strobes and per-port read data; stores return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_q  <= 1'b0;
      resp1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      resp0_q <= in_access && (grant_q == PORT_CORE);
      resp1_q <= in_access && (grant_q == PORT_EXT);
      if (in_access && (grant_q == PORT_CORE)) begin
        rdata0_q <= wen_q ? '0 : mem_rdata;
      end
      if (in_access && (grant_q == PORT_EXT)) begin
        rdata1_q <= wen_q ? '0 : mem_rdata;
      end
    end
  end

  assign in_access = (state_q == ST_ACCESS);

  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wen   = in_access & wen_q;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign mem_mask  = in_access ? mask_q  : MASK_B;

  assign p0_ready      = ready0_c;
  assign p1_ready      = ready1_c;
  assign p0_resp_valid = resp0_q;
  assign p1_resp_valid = resp1_q;
  assign p0_rdata      = rdata0_q;
  assign p1_rdata      = rdata1_q;
  assign busy          = (state_q != ST_IDLE);
  assign grant_id      = grant_q;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width of every address port.
REQ-002 Parameter DATA_W, 32, data width; SHALL be 32 (elaboration error otherwise).
REQ-003 clk  in  1  single clock; every flop rises on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 p0_valid / p1_valid  in  1 each  request valid; p0 = core load/store port, p1 = external loader/debug port.
REQ-006 p0_ready / p1_ready  out  1 each  request accepted this cycle.
REQ-007 pN_addr  in  ADDR_W, pN_wen  in  1, pN_wdata  in  DATA_W, pN_mask  in  3  request fields (mask encoding identical to the datapath byte_mask).
REQ-008 pN_resp_valid  out  1, pN_rdata  out  DATA_W  one-cycle response strobe and read data.
REQ-009 mem_addr  out  ADDR_W, mem_wen  out  1, mem_wdata  out  DATA_W, mem_mask  out  3  data-memory drive.
REQ-010 mem_rdata  in  DATA_W  combinational read data from data memory.
REQ-011 busy  out  1, grant_id  out  1  a transaction is in flight / which port owns it.

Function
REQ-012 FSM states IDLE, ACCESS, RESP; encoding from the shared package.
REQ-013 IDLE: with no valid, stay IDLE with all readies low; with any valid, assert exactly one pN_ready combinationally, latch that port's fields and grant_id, go to ACCESS.
REQ-014 Handshake: acceptance = pN_valid & pN_ready; fields sampled only on acceptance; requesters hold fields stable while valid and not ready.
REQ-015 ACCESS: drive mem_* from latched fields for exactly one cycle; mem_wen = latched wen in ACCESS only, else 0; register mem_rdata; go to RESP.
REQ-016 RESP: pulse p[grant_id]_resp_valid for exactly one cycle with registered data (stores return 0); go to IDLE.
REQ-017 Latency: acceptance at cycle N -> memory access at N+1 -> resp_valid at N+2; next acceptance no earlier than N+3.
REQ-018 Outside ACCESS: mem_addr, mem_wdata, mem_mask, mem_wen = 0.
REQ-019 pN_rdata holds last response value between responses; resp_valid never asserts to the non-owner port.
REQ-020 busy = 1 in ACCESS and RESP; grant_id holds last owner in IDLE.
REQ-021 Both valid in IDLE: winner chosen per REQ-025/026; loser keeps valid, is served no earlier than the following IDLE.
REQ-022 pN_valid dropped without acceptance: no effect; valid during ACCESS/RESP: ready stays low.

Reset
REQ-023 rst asserted: state IDLE, all readies, resp_valids, mem_wen, busy low; grant_id 0; rdata registers 0; round-robin pointer -> p0 preferred.
REQ-024 rst mid-transaction: in-flight request dropped with no memory write and no response; after release, IDLE.

Configuration
REQ-025 DMEM_ARBITER_ROUND_ROBIN_EN defined: on contention, prefer the port not granted last; pointer updates on every acceptance.
REQ-026 Undefined: fixed priority, p0 always wins contention; pointer flop absent.

Structure
REQ-027 Shared package rv32i_pkg holds the FSM state enum, the byte_mask typedef and port-id constants PORT_CORE=0, PORT_EXT=1.
REQ-028 Sub-module dmem_arb_pick (combinational grant pick from two valids and pointer); everything else in dmem_arbiter.

Verification
REQ-029 Reset: rst high mid-ACCESS with p0 store to 0x10 -> mem_wen never asserts, busy 0, memory word 0x10 unchanged.
REQ-030 Single read: p0 valid, addr 0x8, mem word 0xDEADBEEF -> p0_ready cycle N, mem_addr 0x8 at N+1, p0_resp_valid with 0xDEADBEEF at N+2.
REQ-031 Store: p1 store 0x12345678 mask word to 0x20 -> mem_wen high only at N+1; later p0 read of 0x20 returns 0x12345678.
REQ-032 Contention with macro defined: p0 and p1 valid continuously -> grants alternate p0,p1,p0,p1 every 3 cycles.
REQ-033 Contention with macro undefined: same stimulus -> every grant to p0; p1 served in first IDLE after p0 drops valid.
REQ-034 Back-pressure: p1 valid during p0's ACCESS/RESP -> p1_ready low until IDLE; p1 fields unchanged when accepted.
